id_operand_stage: RTL

//  Decode-stage operand unit, parametrised: selects op1/op2 from regfile, immediate or
//  NUM_FWD forwarding sources, detects load-use hazards, and holds operands in a

---
 rtl/id_operand_stage.sv | 127 ++++++++++++
 1 files changed

// File: rtl/id_operand_stage.sv
// rtl/id_operand_stage.sv - decode-stage operand select, load-use hazard detect, registered ID/EX slot (optional ID_STALL_CNT_EN stall counter)
module id_operand_stage #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int NUM_FWD = 2,
  parameter int CTRL_W  = 11
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_rd1,
  input  logic                       in_rd2,
  input  logic [RADDR_W-1:0]         in_ra1,
  input  logic [RADDR_W-1:0]         in_ra2,
  input  logic [DATA_W-1:0]          in_imm,
  input  logic [RADDR_W-1:0]         in_wd,
  input  logic                       in_wreg,
  input  logic [CTRL_W-1:0]          in_ctrl,
  output logic [RADDR_W-1:0]         rf_raddr1,
  output logic [RADDR_W-1:0]         rf_raddr2,
  input  logic [DATA_W-1:0]          rf_rdata1,
  input  logic [DATA_W-1:0]          rf_rdata2,
  input  logic [NUM_FWD-1:0]         fwd_wreg,
  input  logic [NUM_FWD*RADDR_W-1:0] fwd_wd,
  input  logic [NUM_FWD*DATA_W-1:0]  fwd_wdata,
  input  logic [NUM_FWD-1:0]         fwd_ldpend,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_op1,
  output logic [DATA_W-1:0]          out_op2,
  output logic [RADDR_W-1:0]         out_wd,
  output logic                       out_wreg,
  output logic [CTRL_W-1:0]          out_ctrl,
`ifdef ID_STALL_CNT_EN
  output logic [31:0]                stall_cnt,
`endif
  output logic                       stall_req
);

  // Returns {pending, value} for one operand. The forwarding loop runs from the
  // oldest source down to the youngest so the lowest matching index is applied last
  // and wins; its ldpend bit decides the hazard regardless of older matches.
  function automatic logic [DATA_W:0] pick_operand(
    input logic                       rd,
    input logic [RADDR_W-1:0]         ra,
    input logic [DATA_W-1:0]          rf,
    input logic [DATA_W-1:0]          imm,
    input logic [NUM_FWD-1:0]         f_wreg,
    input logic [NUM_FWD*RADDR_W-1:0] f_wd,
    input logic [NUM_FWD*DATA_W-1:0]  f_wdata,
    input logic [NUM_FWD-1:0]         f_ldpend
  );
    logic [DATA_W-1:0] val;
    logic              pend;
    val  = rf;
    pend = 1'b0;
    if (!rd) begin
      val = imm;
    end else if (ra == '0) begin
      val = '0;
    end else begin
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
        if (f_wreg[i] && (f_wd[i*RADDR_W +: RADDR_W] == ra)) begin
          val  = f_wdata[i*DATA_W +: DATA_W];
          pend = f_ldpend[i];
        end
      end
    end
    return {pend, val};
  endfunction

  logic [DATA_W:0]   sel1;
  logic [DATA_W:0]   sel2;
  logic              hazard;
  logic              capture;

  assign rf_raddr1 = in_ra1;
  assign rf_raddr2 = in_ra2;

  // Operand selection and hazard/handshake decode, purely from the current inputs
  always_comb begin
    sel1     = pick_operand(in_rd1, in_ra1, rf_rdata1, in_imm, fwd_wreg, fwd_wd, fwd_wdata, fwd_ldpend);
    sel2     = pick_operand(in_rd2, in_ra2, rf_rdata2, in_imm, fwd_wreg, fwd_wd, fwd_wdata, fwd_ldpend);
    hazard   = in_valid && (sel1[DATA_W] || sel2[DATA_W]);
    in_ready = !hazard && !flush && (!out_valid || out_ready);
    capture  = in_valid && in_ready;
  end

  assign stall_req = hazard;

  // ID/EX slot: flush kills, capture loads (also covers drain+capture), else drain or hold
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_op1   <= '0;
      out_op2   <= '0;
      out_wd    <= '0;
      out_wreg  <= 1'b0;
      out_ctrl  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_op1   <= sel1[DATA_W-1:0];
      out_op2   <= sel2[DATA_W-1:0];
      out_wd    <= in_wd;
      out_wreg  <= in_wreg;
      out_ctrl  <= in_ctrl;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ID_STALL_CNT_EN
  // Saturating count of hazard cycles, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (hazard && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
